// File: rtl/as5600_poll_ctrl_pkg.sv
// Shared types and constants for the AS5600 angle polling sequencer.
package as5600_poll_ctrl_pkg;
   localparam int PHI_RES = 4096;
   localparam int PHI_W   = $clog2(PHI_RES);
   localparam int DPHI_W  = PHI_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_BUSY, ST_FAULT} state_t;
endpackage

// File: rtl/as5600_angle_delta.sv
// Holds the previous accepted angle and forms the wrapped signed delta to a new one.
module as5600_angle_delta
   import as5600_poll_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic [PHI_W-1:0]  new_phi,
   output logic [DPHI_W-1:0] dphi,
   output logic              dvalid
);
   logic [PHI_W-1:0] prev;
   logic             has_prev;
   logic [PHI_W-1:0] diff;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev     <= '0;
         has_prev <= 1'b0;
      end else begin
         if (load) prev <= new_phi;
         if (clr)       has_prev <= 1'b0;
         else if (load) has_prev <= 1'b1;
      end
   end

   // Modulo-PHI_RES subtraction falls out of the natural PHI_W-bit wrap.
   assign diff   = new_phi - prev;
   assign dphi   = has_prev ? {diff[PHI_W-1], diff} : '0;
   assign dvalid = has_prev;
endmodule

// File: rtl/as5600_poll_ctrl.sv
// Paces AS5600 angle reads through the I2C engine, guards each with a watchdog,
// and publishes validated angle, wrapped delta and health flags.
module as5600_poll_ctrl
   import as5600_poll_ctrl_pkg::*;
#(
   parameter logic [31:0] SAMPLE_DIV = 32'd4000,
   parameter logic [31:0] TIMEOUT    = 32'd2000,
   parameter logic [7:0]  ERR_LIMIT  = 8'd4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_enable,
   output logic              i2c_start,
   input  logic              i2c_ready,
   input  logic              i2c_done,
   input  logic [15:0]       i2c_regout,
   output logic              o_en,
   output logic [PHI_W-1:0]  o_phi,
   output logic [DPHI_W-1:0] o_dphi,
   output logic              o_dvalid,
   output logic              o_overrun,
   output logic              o_fault,
   output logic [7:0]        o_err_cnt
);
   state_t state, state_d;

   logic [31:0] tick_cnt, wdog;
   logic [7:0]  consec;
   logic        pending, run, tick, good_word, timeout;
   logic        issue, accept, fail, arm_entry;
   logic [DPHI_W-1:0] dphi;
   logic        dvalid;

   assign run       = i_enable && (state != ST_FAULT);
   assign tick      = run && (tick_cnt == SAMPLE_DIV - 32'd1);
   assign good_word = (i2c_regout[15:12] == 4'd0);
   // wdog is 0 in the first BUSY cycle, so this fires TIMEOUT cycles after start.
   assign timeout   = (wdog == TIMEOUT - 32'd1);
   assign o_fault   = (state == ST_FAULT);
   assign i2c_start = issue && !rst;

   always_comb begin
      state_d   = state;
      issue     = 1'b0;
      accept    = 1'b0;
      fail      = 1'b0;
      arm_entry = 1'b0;
      case (state)
         ST_IDLE: if (i_enable) begin
            arm_entry = 1'b1;
            state_d   = ST_ARM;
         end
         ST_ARM: begin
            if (!i_enable) state_d = ST_IDLE;
            else if (pending && i2c_ready) begin
               issue   = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // A done on the timeout cycle still counts as a completed transfer.
            if (i2c_done && good_word)  accept = 1'b1;
            else if (i2c_done || timeout) fail = 1'b1;
            if (fail && (({1'b0, consec} + 9'd1) >= {1'b0, ERR_LIMIT})) state_d = ST_FAULT;
            else if (accept || fail) state_d = i_enable ? ST_ARM : ST_IDLE;
         end
         ST_FAULT: if (!i_enable) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt  <= '0;
         wdog      <= '0;
         consec    <= '0;
         pending   <= 1'b0;
         o_en      <= 1'b0;
         o_phi     <= '0;
         o_dphi    <= '0;
         o_dvalid  <= 1'b0;
         o_overrun <= 1'b0;
         o_err_cnt <= '0;
      end else begin
         o_en <= accept;
         if (run) tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;

         // A fresh tick on the issue cycle survives so the next sample is not lost.
         if (arm_entry)  pending <= 1'b0;
         else if (tick)  pending <= 1'b1;
         else if (issue) pending <= 1'b0;

         if (issue)                 wdog <= '0;
         else if (state == ST_BUSY) wdog <= wdog + 32'd1;

         if (arm_entry)                      o_overrun <= 1'b0;
         else if (state == ST_BUSY && tick)  o_overrun <= 1'b1;

         if (arm_entry || accept) consec <= '0;
         else if (fail)           consec <= consec + 8'd1;

         if (fail && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;

         if (accept) begin
            o_phi    <= i2c_regout[PHI_W-1:0];
            o_dphi   <= dphi;
            o_dvalid <= dvalid;
         end else if (arm_entry || state_d == ST_FAULT) begin
            o_dvalid <= 1'b0;
         end
      end
   end

   as5600_angle_delta u_delta (
      .clk     (clk),
      .rst     (rst),
      .clr     (arm_entry),
      .load    (accept),
      .new_phi (i2c_regout[PHI_W-1:0]),
      .dphi    (dphi),
      .dvalid  (dvalid)
   );
endmodule

// File: tb/tb_as5600_poll_ctrl.sv
// Randomized scoreboard bench for as5600_poll_ctrl: an engine model answers starts,
// a reference model predicts each sample outcome, a monitor checks DUT publications.
module tb_as5600_poll_ctrl;
   localparam int SD = 40;
   localparam int TO = 50;
   localparam int EL = 3;

   logic        clk = 1'b0, rst = 1'b1, i_enable = 1'b0;
   logic        i2c_ready = 1'b1, i2c_done = 1'b0;
   logic [15:0] i2c_regout = '0;
   logic        i2c_start, o_en, o_dvalid, o_overrun, o_fault;
   logic [11:0] o_phi;
   logic [12:0] o_dphi;
   logic [7:0]  o_err_cnt;

   as5600_poll_ctrl #(.SAMPLE_DIV(32'(SD)), .TIMEOUT(32'(TO)), .ERR_LIMIT(8'(EL))) dut (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i2c_start(i2c_start),
      .i2c_ready(i2c_ready), .i2c_done(i2c_done), .i2c_regout(i2c_regout),
      .o_en(o_en), .o_phi(o_phi), .o_dphi(o_dphi), .o_dvalid(o_dvalid),
      .o_overrun(o_overrun), .o_fault(o_fault), .o_err_cnt(o_err_cnt)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          acc;
      logic [11:0] phi;
      logic [12:0] dphi;
      bit          dvalid;
      logic [7:0]  err;
      bit          fault;
   } exp_t;
   exp_t q[$];
   exp_t m_e;

   int n_tests = 0, n_fail = 0;
   // reference model state
   bit   has_prev = 0, ovr = 0, ph_ok = 0, mon_on = 0;
   int   prev = 0, last_phi = 0, consec = 0, errs = 0, tp = 0, exp_start = 0;
   logic [7:0] last_err = '0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic int pmod(input int a, input int m);
      return ((a % m) + m) % m;
   endfunction

   // Monitor: every publication (o_en pulse or err_cnt step) consumes one prediction.
   always @(negedge clk) begin
      if (!mon_on) last_err = o_err_cnt;
      else begin
         if (o_en) begin
            if (q.size() == 0) check("unexpected_en", {31'd0, o_en}, 32'd0);
            else begin
               m_e = q.pop_front();
               check("en_kind", {31'd0, m_e.acc}, 32'd1);
               check("phi", o_phi, m_e.phi);
               check("dphi", o_dphi, m_e.dphi);
               check("dvalid", o_dvalid, m_e.dvalid);
            end
         end
         if (o_err_cnt != last_err) begin
            if (q.size() == 0) check("unexpected_err", o_err_cnt, last_err);
            else begin
               m_e = q.pop_front();
               check("fail_kind", {31'd0, m_e.acc}, 32'd0);
               check("err_cnt", o_err_cnt, m_e.err);
               check("fault", o_fault, m_e.fault);
               check("phi_hold", o_phi, m_e.phi);
            end
            last_err = o_err_cnt;
         end
      end
   end

   task automatic wait_start(output bit seen, output int s);
      seen = 0;
      s = 0;
      for (int k = 0; k < 3 * SD + TO; k++) begin
         @(negedge clk);
         if (i2c_start) begin
            seen = 1;
            s = cyc;
            break;
         end
      end
   endtask

   // One transfer: L = reply latency (>TO means never), w = reply word, R = ready hold-off.
   task automatic run_xfer(input int L, input logic [15:0] w, input int R);
      bit seen;
      int s, e, d, tf, tb;
      exp_t x;
      wait_start(seen, s);
      check("start_seen", {31'd0, seen}, 32'd1);
      if (!seen) return;
      if (ph_ok) check("start_cycle", s, exp_start);
      else begin
         tp = s - 1;
         ph_ok = 1;
      end
      x.acc = (L <= TO) && (w[15:12] == 4'd0);
      if (x.acc) begin
         d = 0;
         if (has_prev) begin
            d = pmod(int'(w[11:0]) - prev, 4096);
            if (d >= 2048) d -= 4096;
         end
         x.dphi = 13'(d);
         x.dvalid = has_prev;
         has_prev = 1;
         prev = int'(w[11:0]);
         last_phi = prev;
         consec = 0;
         x.fault = 0;
      end else begin
         x.dphi = '0;
         x.dvalid = 0;
         if (errs < 255) errs++;
         consec++;
         x.fault = (consec >= EL);
      end
      x.phi = 12'(last_phi);
      x.err = 8'(errs);
      q.push_back(x);

      @(posedge clk) #1;
      i2c_ready = 1'b0;
      e = s + ((L <= TO) ? L : TO);
      while (cyc < e) @(posedge clk) #1;
      if (L <= TO) begin
         i2c_done = 1'b1;
         i2c_regout = w;
      end
      @(posedge clk) #1;
      i2c_done = 1'b0;
      i2c_regout = 16'($urandom);
      repeat (R) @(posedge clk) #1;
      i2c_ready = 1'b1;
      // ticks fall every SD cycles from the learned phase
      tf = s + pmod(tp - s, SD);
      tb = s + 1 + pmod(tp - s - 1, SD);
      if (tb <= e) ovr = 1;
      check("overrun", o_overrun, ovr);
      exp_start = (e + 1 + R > tf + 1) ? e + 1 + R : tf + 1;
   endtask

   task automatic recover();
      int starts = 0;
      repeat (2 * SD) begin
         @(negedge clk);
         if (i2c_start) starts++;
      end
      check("no_start_in_fault", starts, 0);
      check("fault_flag", o_fault, 1);
      check("dvalid_fault", o_dvalid, 0);
      @(posedge clk) #1;
      i_enable = 1'b0;
      @(posedge clk) #1;
      i_enable = 1'b1;
      @(posedge clk) #1;
      check("fault_cleared", o_fault, 0);
      check("overrun_cleared", o_overrun, 0);
      has_prev = 0; consec = 0; ovr = 0; ph_ok = 0;
   endtask

   task automatic xfer(input int L, input logic [15:0] w, input int R);
      run_xfer(L, w, R);
      if (consec >= EL) recover();
   endtask

   initial begin
      bit   seen;
      int   s, L, R;
      logic [15:0] w;

      repeat (3) @(posedge clk);
      #1;
      check("rst_start", i2c_start, 0);
      check("rst_en", o_en, 0);
      check("rst_phi", o_phi, 0);
      check("rst_dphi", o_dphi, 0);
      check("rst_dvalid", o_dvalid, 0);
      check("rst_overrun", o_overrun, 0);
      check("rst_fault", o_fault, 0);
      check("rst_err", o_err_cnt, 0);
      rst = 1'b0;
      last_err = o_err_cnt;
      mon_on = 1;
      i_enable = 1'b1;

      xfer(30, 16'h0123, 0);
      repeat (3) xfer(30, {4'h0, 12'($urandom)}, 0);
      xfer(20, 16'd4090, $urandom_range(0, 3));
      xfer(20, 16'd5,    $urandom_range(0, 3));
      xfer(20, 16'd4090, $urandom_range(0, 3));
      xfer(20, 16'd0,    $urandom_range(0, 3));
      xfer(20, 16'd2048, $urandom_range(0, 3));
      xfer(25, 16'h1ABC, 0);
      xfer(25, 16'h0ABC, 0);
      xfer(45, 16'h0321, 0);
      xfer(TO, 16'h0555, 0);
      repeat (3) xfer(999, 16'h0000, $urandom_range(0, 3));

      repeat (40) begin
         case ($urandom_range(0, 9))
            0, 1:    L = 999;
            2:       L = TO;
            3:       L = $urandom_range(SD - 1, TO);
            default: L = $urandom_range(1, SD - 2);
         endcase
         if ($urandom_range(0, 4) == 0) w = {4'($urandom_range(1, 15)), 12'($urandom)};
         else                           w = {4'h0, 12'($urandom)};
         R = $urandom_range(0, 3);
         xfer(L, w, R);
      end

      // reset in the middle of a transfer, then a stale done
      wait_start(seen, s);
      check("start_before_rst", {31'd0, seen}, 32'd1);
      @(posedge clk) #1;
      i2c_ready = 1'b0;
      repeat (10) @(posedge clk) #1;
      mon_on = 0;
      rst = 1'b1;
      @(posedge clk) #1;
      check("mid_rst_en", o_en, 0);
      check("mid_rst_phi", o_phi, 0);
      check("mid_rst_dphi", o_dphi, 0);
      check("mid_rst_overrun", o_overrun, 0);
      check("mid_rst_fault", o_fault, 0);
      check("mid_rst_err", o_err_cnt, 0);
      check("mid_rst_start", i2c_start, 0);
      rst = 1'b0;
      check("queue_at_rst", q.size(), 0);
      q.delete();
      has_prev = 0; consec = 0; errs = 0; ovr = 0; ph_ok = 0; last_phi = 0;
      last_err = o_err_cnt;
      mon_on = 1;
      @(posedge clk) #1;
      i2c_done = 1'b1;
      i2c_regout = 16'h0777;
      @(posedge clk) #1;
      i2c_done = 1'b0;
      i2c_ready = 1'b1;
      repeat (3) @(posedge clk) #1;
      check("stale_phi", o_phi, 0);
      check("stale_err", o_err_cnt, 0);
      xfer(10, 16'h0ABC, 0);
      xfer(12, 16'h0AB0, 1);

      repeat (5) @(posedge clk);
      check("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
